// File: rtl/gcd_pkg.sv
// +----------------------------------------------------------------------+
// | gcd_pkg : shared FSM state type and width helpers for gcd_stein_seq  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package gcd_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SHIFT  = 3'd2,
    REDUCE = 3'd3,
    DONE   = 3'd4
  } gcd_state_e;

  function automatic int iters_w(input int nbits);
    return $clog2(2 * nbits + 3);
  endfunction

  function automatic int k_w(input int nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/gcd_mag.sv
// +----------------------------------------------------------------------+
// | gcd_mag : combinational two's-complement to unsigned magnitude       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gcd_mag #(
  parameter int NBits = 16
) (
  input  logic [NBits-1:0] i_val,
  output logic [NBits-1:0] o_mag
);

  // The most-negative input negates onto itself, which read as unsigned is
  // exactly its magnitude.
  assign o_mag = i_val[NBits-1] ? (~i_val + {{(NBits-1){1'b0}}, 1'b1}) : i_val;

endmodule

`default_nettype wire

// File: rtl/gcd_stein_seq.sv
// +----------------------------------------------------------------------+
// | gcd_stein_seq : sequential binary (Stein) GCD of two signed operands |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module gcd_stein_seq
  import gcd_pkg::*;
#(
  parameter int NBits = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NBits-1:0]            xi,
  input  logic [NBits-1:0]            yi,
  output logic [NBits-1:0]            xo,
  output logic                        rdy,
  output logic                        busy,
  output logic [iters_w(NBits)-1:0]   iters
);

  localparam int c_IW = iters_w(NBits);
  localparam int c_KW = k_w(NBits);

  gcd_state_e         r_state, w_state_nx;
  logic [NBits-1:0]   r_a, w_a_nx;
  logic [NBits-1:0]   r_b, w_b_nx;
  logic [c_KW-1:0]    r_k, w_k_nx;
  logic [NBits-1:0]   r_xo, w_xo_nx;
  logic [c_IW-1:0]    r_iters, w_iters_nx;
  logic               r_rdy, r_busy;
  logic               w_busy_nx;
  logic [NBits-1:0]   w_mag_x, w_mag_y;

  gcd_mag #(.NBits(NBits)) u_mag_x (.i_val(xi), .o_mag(w_mag_x));
  gcd_mag #(.NBits(NBits)) u_mag_y (.i_val(yi), .o_mag(w_mag_y));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_k     <= '0;
      r_xo    <= '0;
      r_iters <= '0;
      r_rdy   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_k     <= w_k_nx;
      r_xo    <= w_xo_nx;
      r_iters <= w_iters_nx;
      r_rdy   <= (w_state_nx == DONE);
      r_busy  <= w_busy_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_k_nx     = r_k;
    w_xo_nx    = r_xo;
    w_iters_nx = r_iters;

    if ((r_state == CHECK || r_state == SHIFT || r_state == REDUCE) && (r_iters != '1))
      w_iters_nx = r_iters + c_IW'(1);

    case (r_state)
      IDLE: begin
        if (start) begin
          w_a_nx     = w_mag_x;
          w_b_nx     = w_mag_y;
          w_k_nx     = '0;
          w_iters_nx = '0;
          w_state_nx = CHECK;
        end
      end
      CHECK: begin
        if (r_a == '0 && r_b == '0) begin
          w_xo_nx    = '0;
          w_state_nx = DONE;
        end else if (r_a == '0) begin
          w_xo_nx    = r_b;
          w_state_nx = DONE;
        end else if (r_b == '0) begin
          w_xo_nx    = r_a;
          w_state_nx = DONE;
        end else if (!r_a[0] && !r_b[0]) begin
          w_state_nx = SHIFT;
        end else begin
          w_state_nx = REDUCE;
        end
      end
      SHIFT: begin
        w_a_nx = r_a >> 1;
        w_b_nx = r_b >> 1;
        w_k_nx = r_k + c_KW'(1);
        // Bit 1 of the current values is bit 0 after this shift.
        w_state_nx = (!r_a[1] && !r_b[1]) ? SHIFT : REDUCE;
      end
      REDUCE: begin
        if (!r_a[0]) begin
          w_a_nx = r_a >> 1;
        end else if (!r_b[0]) begin
          w_b_nx = r_b >> 1;
        end else if (r_a == r_b) begin
          w_xo_nx    = r_a << r_k;
          w_state_nx = DONE;
        end else if (r_a > r_b) begin
          w_a_nx = (r_a - r_b) >> 1;
        end else begin
          w_b_nx = (r_b - r_a) >> 1;
        end
      end
      DONE: begin
        if (!start)
          w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase

    w_busy_nx = (w_state_nx == CHECK) || (w_state_nx == SHIFT) || (w_state_nx == REDUCE);
  end

  assign xo    = r_xo;
  assign rdy   = r_rdy;
  assign busy  = r_busy;
  assign iters = r_iters;

endmodule

`default_nettype wire

// File: tb/tb_gcd_stein_seq.sv
// +----------------------------------------------------------------------+
// | tb_gcd_stein_seq : directed bench for 16-bit and 8-bit GCD engines   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_gcd_stein_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        start16 = 1'b0;
  logic [15:0] xi16 = '0, yi16 = '0, xo16;
  logic        rdy16, busy16;
  logic [5:0]  iters16;

  logic        start8 = 1'b0;
  logic [7:0]  xi8 = '0, yi8 = '0, xo8;
  logic        rdy8, busy8;
  logic [4:0]  iters8;

  int n_tests = 0;
  int n_fail  = 0;
  int lat;

  always #5 clk = ~clk;

  gcd_stein_seq #(.NBits(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .xi(xi16), .yi(yi16),
    .xo(xo16), .rdy(rdy16), .busy(busy16), .iters(iters16)
  );

  gcd_stein_seq #(.NBits(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .xi(xi8), .yi(yi8),
    .xo(xo8), .rdy(rdy8), .busy(busy8), .iters(iters8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one 16-bit operation end to end; lat = edges after capture until rdy.
  task automatic op16(input string tag, input logic [15:0] x, input logic [15:0] y,
                      input logic [15:0] exp_xo, input int exp_it, output int lt);
    @(negedge clk);
    xi16 = x; yi16 = y; start16 = 1'b1;
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy16), 32'd1);
    lt = 0;
    while (!rdy16 && lt < 40) begin
      @(negedge clk);
      lt++;
      xi16 = 16'h5a5a; yi16 = 16'h0f0f;
    end
    check({tag, "_rdy"}, 32'(rdy16), 32'd1);
    check({tag, "_xo"}, 32'(xo16), 32'(exp_xo));
    if (exp_it >= 0) begin
      check({tag, "_iters"}, 32'(iters16), 32'(exp_it));
      check({tag, "_lat"}, 32'(lt), 32'(exp_it));
    end
    @(negedge clk);
    @(negedge clk);
    check({tag, "_hold_rdy"}, 32'(rdy16), 32'd1);
    check({tag, "_hold_xo"}, 32'(xo16), 32'(exp_xo));
    start16 = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_fall"}, 32'(rdy16), 32'd0);
  endtask

  task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic [7:0] exp_xo, input int exp_it);
    int lt;
    @(negedge clk);
    xi8 = x; yi8 = y; start8 = 1'b1;
    @(negedge clk);
    check({tag, "_busy"}, 32'(busy8), 32'd1);
    lt = 0;
    while (!rdy8 && lt < 30) begin
      @(negedge clk);
      lt++;
    end
    check({tag, "_xo"}, 32'(xo8), 32'(exp_xo));
    check({tag, "_iters"}, 32'(iters8), 32'(exp_it));
    check({tag, "_lat"}, 32'(lt), 32'(exp_it));
    start8 = 1'b0;
    @(negedge clk);
    check({tag, "_rdy_fall"}, 32'(rdy8), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_xo", 32'(xo16), 32'd0);
    check("rst_rdy", 32'(rdy16), 32'd0);
    check("rst_busy", 32'(busy16), 32'd0);
    check("rst_iters", 32'(iters16), 32'd0);
    check("rst_xo8", 32'(xo8), 32'd0);
    rst = 1'b1;

    op16("g48_18", 16'd48, 16'd18, 16'd6, 7, lat);
    op16("gm12_8", -16'sd12, 16'd8, 16'd4, 6, lat);
    op16("g17_m17", 16'd17, -16'sd17, 16'd17, -1, lat);

    op8("m128_64", 8'h80, 8'd64, 8'd64, 9);
    op8("m128_m128", 8'h80, 8'h80, 8'h80, 9);
    op8("z0_0", 8'd0, 8'd0, 8'd0, 1);
    op8("z0_m7", 8'd0, 8'hf9, 8'd7, 1);

    op16("m1_m2", 16'hffff, 16'hfffe, 16'd1, 3, lat);
    check("m1_m2_bound", 32'(lat <= 34), 32'd1);

    // Abort an operation with an asynchronous reset between clock edges.
    @(negedge clk);
    xi16 = 16'd48; yi16 = 16'd18; start16 = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(busy16), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort_xo", 32'(xo16), 32'd0);
    check("abort_rdy", 32'(rdy16), 32'd0);
    check("abort_busy0", 32'(busy16), 32'd0);
    check("abort_iters", 32'(iters16), 32'd0);
    start16 = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    op16("g21_14", 16'd21, 16'd14, 16'd7, 4, lat);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
